// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Bits needed to count 0..w iterations.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand, accumulator and iteration-counter registers plus the shift-add adder.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  output logic                 last_iter,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? -x : x;
  endfunction

  // WIDTH+1-bit add into the upper accumulator half, keeping the carry.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  end

  // Sign fix-up of the unsigned magnitude product; a zero product stays zero.
  always_comb begin
    product   = neg ? -acc : acc;
    last_iter = (cnt == LAST);
  end

  // Capture operands on load, then one shift-add iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mag(in_1, signed_mode);
      mplier <= mag(in_2, signed_mode);
      neg    <= signed_mode & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      // {carry, acc} >> 1: the carry lands in the accumulator MSB.
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential signed/unsigned multiplier with start/ready handshake.
module seq_mult_param #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  output logic [2*WIDTH-1:0]   out,
  output logic                 ready,
  output logic                 busy
);
  import seq_mult_pkg::*;

  state_t             state, state_next;
  logic               load, step, last_iter;
  logic [2*WIDTH-1:0] product;

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .signed_mode (signed_mode),
    .in_1        (in_1),
    .in_2        (in_2),
    .last_iter   (last_iter),
    .product     (product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_iter) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result register and completion pulse, both updated on the edge leaving FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      ready <= 1'b0;
    end else begin
      ready <= (state == FIX);
      if (state == FIX) out <= product;
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param at WIDTH=4 and WIDTH=8.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst;

  logic       st4, sm4, r4, bz4;
  logic [3:0] a4, b4;
  logic [7:0] o4;

  logic        st8, sm8, r8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
    .in_1(a4), .in_2(b4), .out(o4), .ready(r4), .busy(bz4)
  );

  seq_mult_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .in_1(a8), .in_2(b8), .out(o8), .ready(r8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers and multiply, modulo 2^(2w).
  function automatic logic [63:0] ref_prod(input int unsigned w, input logic sm,
                                           input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    x = longint'(a & m);
    y = longint'(b & m);
    if (sm && a[w-1]) x = x - (64'sd1 <<< w);
    if (sm && b[w-1]) y = y - (64'sd1 <<< w);
    p = x * y;
    return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic drive(input int unsigned w, input logic st, input logic sm,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 4) begin st4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0]; end
    else        begin st8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
  endtask

  function automatic logic [63:0] obs_out(input int unsigned w);
    return (w == 4) ? 64'(o4) : 64'(o8);
  endfunction
  function automatic logic obs_rdy(input int unsigned w);
    return (w == 4) ? r4 : r8;
  endfunction
  function automatic logic obs_busy(input int unsigned w);
    return (w == 4) ? bz4 : bz8;
  endfunction

  // One start pulse, then wait (bounded) for ready and check timing and product.
  task automatic run_op(input string tag, input int unsigned w, input logic sm,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expv;
    int n, bc;
    expv = ref_prod(w, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b1, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, sm, a, b);
    n = 0; bc = 0;
    while (!obs_rdy(w) && n < int'(3*w + 10)) begin
      bc += int'(obs_busy(w));
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(w + 1));
    check({tag, "/busy_cycles"}, 64'(bc), 64'(w + 1));
    check({tag, "/out"}, obs_out(w), expv);
    check({tag, "/busy_at_ready"}, 64'(obs_busy(w)), 64'd0);
    @(posedge clk); #1;
    check({tag, "/ready_single"}, 64'(obs_rdy(w)), 64'd0);
    check({tag, "/out_hold"}, obs_out(w), expv);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, last, n;
    logic [63:0] cap, expv;
    logic [31:0] ra, rb;
    logic rs;

    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset/out4", 64'(o4), 64'd0);
    check("reset/ready4", 64'(r4), 64'd0);
    check("reset/busy4", 64'(bz4), 64'd0);
    check("reset/out8", 64'(o8), 64'd0);
    check("reset/busy8", 64'(bz8), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_op("u4_6x9",    4, 1'b0, 32'h6,  32'h9);
    run_op("s4_6xm7",   4, 1'b1, 32'h6,  32'h9);
    run_op("s4_m8xm8",  4, 1'b1, 32'h8,  32'h8);
    run_op("s4_m5x0",   4, 1'b1, 32'hB,  32'h0);
    run_op("u4_15x15",  4, 1'b0, 32'hF,  32'hF);
    run_op("u8_ffxff",  8, 1'b0, 32'hFF, 32'hFF);
    run_op("s8_80x7f",  8, 1'b1, 32'h80, 32'h7F);
    run_op("s8_80x80",  8, 1'b1, 32'h80, 32'h80);
    run_op("s8_0xm1",   8, 1'b1, 32'h00, 32'hFF);
    check("const/u4_6x9", ref_prod(4, 1'b0, 6, 9), 64'h36);

    // Inputs changed and start re-pulsed mid-CALC are ignored.
    @(posedge clk); #1;
    drive(4, 1'b1, 1'b0, 32'h6, 32'h9);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 32'h6, 32'h9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(4, 1'b1, 1'b1, 32'hF, 32'hD);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b1, 32'hF, 32'hD);
    pulses = 0; cap = '0;
    for (int i = 0; i < 12; i++) begin
      if (r4) begin pulses++; cap = 64'(o4); end
      @(posedge clk); #1;
    end
    check("midcalc/pulses", 64'(pulses), 64'd1);
    check("midcalc/out", cap, 64'h36);

    // Reset during the 3rd CALC cycle aborts the operation.
    @(posedge clk); #1;
    drive(4, 1'b1, 1'b0, 32'h7, 32'h5);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 32'h7, 32'h5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort/out", 64'(o4), 64'd0);
    check("abort/busy", 64'(bz4), 64'd0);
    check("abort/ready", 64'(r4), 64'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (r4) pulses++;
      @(posedge clk); #1;
    end
    check("abort/no_pulse", 64'(pulses), 64'd0);
    run_op("after_abort", 4, 1'b0, 32'h7, 32'h5);

    // Start held high: back-to-back issue, inputs changed after each completion.
    for (int unsigned w = 4; w <= 8; w += 4) begin
      @(posedge clk); #1;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      drive(w, 1'b1, rs, ra, rb);
      expv = ref_prod(w, rs, ra, rb);
      cap = '0; pulses = 0; last = 0; n = 0;
      while (pulses < 3 && n < int'(4*(w + 2) + 10)) begin
        @(posedge clk); #1;
        n++;
        if (obs_rdy(w)) begin
          check("held/out", obs_out(w), expv);
          if (pulses > 0) check("held/spacing", 64'(n - last), 64'(w + 2));
          last = n; pulses++;
          cap = expv;
          ra = $urandom; rb = $urandom; rs = 1'($urandom);
          drive(w, pulses < 3, rs, ra, rb);
          expv = ref_prod(w, rs, ra, rb);
        end else if (pulses > 0) begin
          check("held/stable", obs_out(w), cap);
        end
      end
      check("held/pulses", 64'(pulses), 64'd3);
      drive(w, 1'b0, 1'b0, 0, 0);
      repeat (w + 3) @(posedge clk);
    end

    // Randomized operations on both widths.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      run_op("rand4", 4, rs, ra, rb);
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      run_op("rand8", 8, rs, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
